// File: rtl/clkdiv_seq_pkg.sv
// rtl/clkdiv_seq_pkg.sv - shared states, widths and output decode for the clock-divider sequencer
package clkdiv_seq_pkg;

  localparam int RELOCK_W = 8;

  typedef enum logic [2:0] {
    S_WAIT_LOCK   = 3'd0,
    S_DIV_RELEASE = 3'd1,
    S_CLK_START   = 3'd2,
    S_READY       = 3'd3,
    S_CALIB       = 3'd4,
    S_CAL_GAP     = 3'd5
  } state_t;

  typedef struct packed {
    logic clk_stop;
    logic div_resetn;
    logic io_reset;
    logic calib;
    logic ready;
    logic cal_busy;
  } seq_out_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Output levels are a pure function of the state being entered.
  function automatic seq_out_t outputs_for(input state_t s);
    seq_out_t o;
    o.clk_stop   = (s == S_WAIT_LOCK) || (s == S_DIV_RELEASE);
    o.div_resetn = (s != S_WAIT_LOCK);
    o.io_reset   = (s == S_WAIT_LOCK) || (s == S_DIV_RELEASE) || (s == S_CLK_START);
    o.calib      = (s == S_CALIB);
    o.ready      = (s == S_READY);
    o.cal_busy   = (s == S_CALIB) || (s == S_CAL_GAP);
    return o;
  endfunction

endpackage

// File: rtl/clkdiv_sequencer_if.sv
// rtl/clkdiv_sequencer_if.sv - lock/calibration request and divider control bundle
interface clkdiv_sequencer_if;
  import clkdiv_seq_pkg::*;

  logic                pll_lock;
  logic                calib_req;
  logic                clk_stop;
  logic                div_resetn;
  logic                io_reset;
  logic                calib;
  logic                ready;
  logic                cal_busy;
  logic [RELOCK_W-1:0] relock_cnt;

  modport master (
    output pll_lock, calib_req,
    input  clk_stop, div_resetn, io_reset, calib, ready, cal_busy, relock_cnt
  );

  modport slave (
    input  pll_lock, calib_req,
    output clk_stop, div_resetn, io_reset, calib, ready, cal_busy, relock_cnt
  );
endinterface

// File: rtl/clkdiv_sequencer_core.sv
// rtl/clkdiv_sequencer_core.sv - lock-qualified bring-up and calibration FSM for the clock divider
module clkdiv_sequencer_core
  import clkdiv_seq_pkg::*;
#(
  parameter int LOCK_CYCLES = 256,
  parameter int STEP_CYCLES = 8,
  parameter int CALIB_GAP   = 16
) (
  input  logic             clock,
  input  logic             resetn,
  clkdiv_sequencer_if.slave bus
);

  localparam int CNT_MAX = max3(LOCK_CYCLES, STEP_CYCLES, CALIB_GAP);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(CALIB_GAP - 1);

  logic                lock_s;
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RELOCK_W-1:0] relock_q, relock_d;
  seq_out_t            out_q, out_d;

  sync_ff #(.STAGES(2)) u_lock_sync (
    .clk_i  (clock),
    .rst_ni (resetn),
    .d_i    (bus.pll_lock),
    .q_o    (lock_s)
  );

  // Next state, shared step counter and relock count; lock loss overrides everything.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    relock_d = relock_q;
    if (state_q != S_WAIT_LOCK && !lock_s) begin
      state_d = S_WAIT_LOCK;
      cnt_d   = '0;
      if ((state_q == S_READY || state_q == S_CALIB || state_q == S_CAL_GAP) &&
          relock_q != {RELOCK_W{1'b1}}) begin
        relock_d = relock_q + RELOCK_W'(1);
      end
    end else begin
      case (state_q)
        S_WAIT_LOCK: begin
          if (!lock_s) begin
            cnt_d = '0;
          end else if (cnt_q == LOCK_LAST) begin
            state_d = S_DIV_RELEASE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_DIV_RELEASE: begin
          if (cnt_q == STEP_LAST) begin
            state_d = S_CLK_START;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_CLK_START: begin
          if (cnt_q == STEP_LAST) begin
            state_d = S_READY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_READY: begin
          cnt_d = '0;
          if (bus.calib_req) state_d = S_CALIB;
        end
        S_CALIB: begin
          state_d = S_CAL_GAP;
          cnt_d   = '0;
        end
        S_CAL_GAP: begin
          // Requests arriving here are intentionally dropped.
          if (cnt_q == GAP_LAST) begin
            state_d = S_READY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end
      endcase
    end
    out_d = outputs_for(state_d);
  end

  // State, counter, relock count and registered outputs all move on the same edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_WAIT_LOCK;
      cnt_q    <= '0;
      relock_q <= '0;
      out_q    <= outputs_for(S_WAIT_LOCK);
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      relock_q <= relock_d;
      out_q    <= out_d;
    end
  end

  assign bus.clk_stop   = out_q.clk_stop;
  assign bus.div_resetn = out_q.div_resetn;
  assign bus.io_reset   = out_q.io_reset;
  assign bus.calib      = out_q.calib;
  assign bus.ready      = out_q.ready;
  assign bus.cal_busy   = out_q.cal_busy;
  assign bus.relock_cnt = relock_q;

endmodule

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-stage flop synchronizer, resets to 0
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= (sync_q << 1) | STAGES'(d_i);
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/clkdiv_sequencer.sv
// rtl/clkdiv_sequencer.sv - clock-divider bring-up and bitslip calibration sequencer top
module clkdiv_sequencer
  import clkdiv_seq_pkg::*;
#(
  parameter int LOCK_CYCLES = 256,
  parameter int STEP_CYCLES = 8,
  parameter int CALIB_GAP   = 16
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                pll_lock,
  input  logic                calib_req,
  output logic                clk_stop,
  output logic                div_resetn,
  output logic                io_reset,
  output logic                calib,
  output logic                ready,
  output logic                cal_busy,
  output logic [RELOCK_W-1:0] relock_cnt
);

  clkdiv_sequencer_if u_bus ();

  assign u_bus.pll_lock  = pll_lock;
  assign u_bus.calib_req = calib_req;

  clkdiv_sequencer_core #(
    .LOCK_CYCLES (LOCK_CYCLES),
    .STEP_CYCLES (STEP_CYCLES),
    .CALIB_GAP   (CALIB_GAP)
  ) u_core (
    .clock  (clock),
    .resetn (resetn),
    .bus    (u_bus.slave)
  );

  assign clk_stop   = u_bus.clk_stop;
  assign div_resetn = u_bus.div_resetn;
  assign io_reset   = u_bus.io_reset;
  assign calib      = u_bus.calib;
  assign ready      = u_bus.ready;
  assign cal_busy   = u_bus.cal_busy;
  assign relock_cnt = u_bus.relock_cnt;

endmodule

// File: tb/tb_clkdiv_sequencer.sv
// tb/tb_clkdiv_sequencer.sv - self-checking bench for clkdiv_sequencer
module tb_clkdiv_sequencer;

  localparam int LOCK = 4;
  localparam int STEP = 2;
  localparam int GAP  = 3;

  // {clk_stop, div_resetn, io_reset, calib, ready, cal_busy}
  localparam logic [5:0] WAIT_VEC = 6'b101000;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  clkdiv_sequencer_if bus ();

  clkdiv_sequencer #(
    .LOCK_CYCLES (LOCK),
    .STEP_CYCLES (STEP),
    .CALIB_GAP   (GAP)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .pll_lock   (bus.pll_lock),
    .calib_req  (bus.calib_req),
    .clk_stop   (bus.clk_stop),
    .div_resetn (bus.div_resetn),
    .io_reset   (bus.io_reset),
    .calib      (bus.calib),
    .ready      (bus.ready),
    .cal_busy   (bus.cal_busy),
    .relock_cnt (bus.relock_cnt)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phases with fixed dwell lengths, lock seen two edges late.
  localparam int PH_WAIT = 0, PH_REL = 1, PH_START = 2, PH_READY = 3, PH_CALIB = 4, PH_GAP = 5;
  int m_phase   = PH_WAIT;
  int m_elapsed = 0;
  int m_run     = 0;
  int m_relock  = 0;
  bit m_s1      = 1'b0;
  bit m_s2      = 1'b0;

  always @(posedge clock or negedge resetn) begin
    bit ls;
    ls = m_s2;
    if (!resetn) begin
      m_phase = PH_WAIT; m_elapsed = 0; m_run = 0; m_relock = 0; m_s1 = 0; m_s2 = 0;
    end else begin
      if (m_phase != PH_WAIT && !ls) begin
        if (m_phase >= PH_READY && m_relock < 255) m_relock++;
        m_phase = PH_WAIT;
        m_run   = 0;
      end else begin
        case (m_phase)
          PH_WAIT: begin
            m_run = ls ? m_run + 1 : 0;
            if (m_run == LOCK) begin m_phase = PH_REL; m_elapsed = 0; end
          end
          PH_REL: begin
            m_elapsed++;
            if (m_elapsed == STEP) begin m_phase = PH_START; m_elapsed = 0; end
          end
          PH_START: begin
            m_elapsed++;
            if (m_elapsed == STEP) begin m_phase = PH_READY; m_elapsed = 0; end
          end
          PH_READY: if (bus.calib_req) m_phase = PH_CALIB;
          PH_CALIB: begin m_phase = PH_GAP; m_elapsed = 0; end
          default: begin
            m_elapsed++;
            if (m_elapsed == GAP) begin m_phase = PH_READY; m_elapsed = 0; end
          end
        endcase
      end
      m_s2 = m_s1;
      m_s1 = bus.pll_lock;
    end
  end

  function automatic logic [5:0] model_vec(input int ph);
    return {ph <= PH_REL, ph != PH_WAIT, ph <= PH_START,
            ph == PH_CALIB, ph == PH_READY, ph == PH_CALIB || ph == PH_GAP};
  endfunction

  function automatic logic [5:0] dut_vec();
    return {bus.clk_stop, bus.div_resetn, bus.io_reset, bus.calib, bus.ready, bus.cal_busy};
  endfunction

  // Every cycle, compare all outputs against the model just after the edge.
  always @(posedge clock) begin
    #1;
    check("model_outputs", dut_vec(), model_vec(m_phase));
    check("model_relock", bus.relock_cnt, m_relock);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    bus.pll_lock  = 1'b0;
    bus.calib_req = 1'b0;
    tick(2);
    resetn = 1'b1;
  endtask

  task automatic wait_ready(input string name);
    int k;
    k = 0;
    while (bus.ready !== 1'b1 && k < 60) begin tick(); k++; end
    check(name, bus.ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n_cal, n_busy, n_nrdy, timeouts;

    // Reset state and bring-up latencies from pll_lock.
    do_reset();
    check("reset_outputs", dut_vec(), WAIT_VEC);
    check("reset_relock", bus.relock_cnt, 0);
    bus.pll_lock = 1'b1;
    k = 0; while (!bus.div_resetn && k < 40) begin tick(); k++; end
    check("bringup_div_resetn_delay", k, 6);
    k = 0; while (bus.clk_stop && k < 40) begin tick(); k++; end
    check("bringup_clk_stop_delay", k, 2);
    k = 0; while (!bus.ready && k < 40) begin tick(); k++; end
    check("bringup_ready_delay", k, 2);
    check("bringup_io_reset_low", bus.io_reset, 0);

    // One-cycle glitch after three lock_s cycles restarts the count.
    do_reset();
    bus.pll_lock = 1'b1;
    tick(3);
    bus.pll_lock = 1'b0;
    tick(1);
    bus.pll_lock = 1'b1;
    k = 0; while (!bus.div_resetn && k < 40) begin tick(); k++; end
    check("glitch_div_resetn_delay", k, 6);
    wait_ready("glitch_reach_ready");

    // Calibration with a second request landing in the gap.
    n_cal = 0; n_busy = 0; n_nrdy = 0;
    bus.calib_req = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      bus.calib_req = (i == 2);
      n_cal  += int'(bus.calib);
      n_busy += int'(bus.cal_busy);
      n_nrdy += int'(!bus.ready);
    end
    check("calib_pulses", n_cal, 1);
    check("calib_busy_cycles", n_busy, 4);
    check("calib_ready_low_cycles", n_nrdy, 4);
    check("calib_back_ready", bus.ready, 1);

    // Lock loss from READY.
    bus.pll_lock = 1'b0;
    tick(3);
    check("lockloss_outputs", dut_vec(), WAIT_VEC);
    check("lockloss_relock", bus.relock_cnt, 1);
    bus.pll_lock = 1'b1;
    wait_ready("lockloss_rerun_ready");

    // Saturation over 300 further lock-loss events.
    timeouts = 0;
    for (int i = 0; i < 300; i++) begin
      bus.pll_lock = 1'b0;
      tick(3);
      bus.pll_lock = 1'b1;
      k = 0; while (!bus.ready && k < 40) begin tick(); k++; end
      if (k >= 40) timeouts++;
      if (i == 252) check("sat_relock_254", bus.relock_cnt, 254);
    end
    check("sat_timeouts", timeouts, 0);
    bus.pll_lock = 1'b0;
    tick(3);
    check("sat_relock_255", bus.relock_cnt, 255);
    bus.pll_lock = 1'b1;
    wait_ready("sat_rerun_ready");

    // Asynchronous reset in the middle of the calibration gap.
    bus.calib_req = 1'b1;
    tick();
    bus.calib_req = 1'b0;
    tick();
    check("async_in_gap", bus.cal_busy, 1);
    #2;
    resetn = 1'b0;
    #1;
    check("async_reset_outputs", dut_vec(), WAIT_VEC);
    check("async_reset_relock", bus.relock_cnt, 0);
    tick();
    resetn = 1'b1;

    // Randomized lock drops and calibration requests against the model.
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (bus.pll_lock) begin
        if ($urandom_range(0, 39) == 0) bus.pll_lock = 1'b0;
      end else begin
        if ($urandom_range(0, 3) == 0) bus.pll_lock = 1'b1;
      end
      bus.calib_req = ($urandom_range(0, 5) == 0);
    end
    bus.calib_req = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clkdiv_sequencer.md
CLKDIV_SEQUENCER -- requirements
Module: clkdiv_sequencer

Interface
REQ-001 SHALL have parameter LOCK_CYCLES, default 256, meaning consecutive synchronized-lock cycles required before sequencing starts (>=1).
REQ-002 SHALL have parameter STEP_CYCLES, default 8, meaning the dwell of each sequencing step in clock cycles (>=1).
REQ-003 SHALL have parameter CALIB_GAP, default 16, meaning the minimum idle cycles after each CALIB pulse (>=1).
REQ-004 SHALL have port clock, input, 1, free-running reference clock that is not derived from the divider.
REQ-005 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port pll_lock, input, 1, PLL lock indicator, asynchronous to clock.
REQ-007 SHALL have port calib_req, input, 1, single-cycle word-alignment (bitslip) request.
REQ-008 SHALL have port clk_stop, output, 1, high gates the fast clock (DHCEN control).
REQ-009 SHALL have port div_resetn, output, 1, active-low reset to the clock divider.
REQ-010 SHALL have port io_reset, output, 1, active-high reset to the deserializer IO logic.
REQ-011 SHALL have port calib, output, 1, divider CALIB pulse.
REQ-012 SHALL have port ready, output, 1, high when the divided clock is running and alignment is idle.
REQ-013 SHALL have port cal_busy, output, 1, high during a calibration pulse and its gap.
REQ-014 SHALL have port relock_cnt, output, 8, saturating count of lock losses after READY was first reached.

Function
REQ-015 SHALL synchronize pll_lock through two flops into lock_s; all decisions use lock_s only.
REQ-016 SHALL implement states WAIT_LOCK, DIV_RELEASE, CLK_START, READY, CALIB, CAL_GAP; all outputs registered and updated on the same edge as the state transition.
REQ-017 WAIT_LOCK: clk_stop=1, div_resetn=0, io_reset=1, calib=0, ready=0, cal_busy=0; counter increments while lock_s=1 and clears when lock_s=0; after LOCK_CYCLES consecutive lock_s=1 cycles -> DIV_RELEASE.
REQ-018 DIV_RELEASE: div_resetn=1, clk_stop=1, io_reset=1 for exactly STEP_CYCLES cycles -> CLK_START.
REQ-019 CLK_START: clk_stop=0, div_resetn=1, io_reset=1 for exactly STEP_CYCLES cycles -> READY.
REQ-020 READY: clk_stop=0, div_resetn=1, io_reset=0, ready=1; calib_req=1 -> CALIB.
REQ-021 CALIB: calib=1, ready=0, cal_busy=1 for exactly one cycle -> CAL_GAP.
REQ-022 CAL_GAP: calib=0, cal_busy=1, ready=0 for exactly CALIB_GAP cycles -> READY; calib_req in CALIB or CAL_GAP SHALL be dropped, not queued.
REQ-023 lock_s=0 in any state other than WAIT_LOCK SHALL transition to WAIT_LOCK on the next edge with WAIT_LOCK outputs and a cleared counter; lock loss takes priority over calib_req and step completion in the same cycle.
REQ-024 relock_cnt SHALL increment by one on each lock loss from READY, CALIB or CAL_GAP, and SHALL hold at 255.
REQ-025 A single shared step counter SHALL be sized by clog2 of max(LOCK_CYCLES, STEP_CYCLES, CALIB_GAP)+1 and SHALL clear on every state entry.

Reset
REQ-026 resetn low SHALL immediately force state WAIT_LOCK, clk_stop=1, div_resetn=0, io_reset=1, calib=0, ready=0, cal_busy=0, relock_cnt=0, counter=0, and both sync flops=0, regardless of the current state.
REQ-027 Reset release SHALL be the only path that clears relock_cnt.

Structure
REQ-028 The state enumeration and the relock_cnt width SHALL live in package clkdiv_seq_pkg.
REQ-029 The two-flop synchronizer SHALL be a separate sub-module named sync_ff, with parameterized stages (default 2) and reset value 0.

Verification (LOCK_CYCLES=4, STEP_CYCLES=2, CALIB_GAP=3)
REQ-030 Bring-up check: after reset, hold pll_lock high; div_resetn rises 6 cycles after pll_lock, clk_stop falls 2 cycles later, and io_reset falls with ready rising 2 cycles after that.
REQ-031 Lock-glitch check: drop pll_lock for 1 cycle after 3 lock_s cycles; the lock count restarts, and div_resetn rises 4 cycles after lock_s returns high.
REQ-032 Calibration check: pulse calib_req in READY, then again 2 cycles later; the bench sees exactly one calib pulse, cal_busy high for 4 cycles, ready low for 4 cycles, and the second request is ignored.
REQ-033 Lock-loss check: drop pll_lock in READY; within 3 cycles all outputs match WAIT_LOCK values and relock_cnt=1; the sequence re-runs when lock returns.
REQ-034 Saturation check: apply 300 lock-loss events, each after READY is reached; relock_cnt reads 255.
REQ-035 Async-reset check: assert resetn mid CAL_GAP; outputs take reset values without waiting for a clock edge, and relock_cnt=0.
